alarm_setter: RTL and testbench

//   Alarm-time entry and storage for the alarm-clock mode. Merges a 24-hour editor
//   (states IDLE/HOUR/MIN), a 12-hour editor (IDLE/AMPM/HOUR/MIN) and the stored alarm register.

---
 rtl/alarm_setter.sv | 147 ++++++++++++++
 tb/tb_alarm_setter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alarm_setter.sv
// Alarm-time editor (24h and 12h entry) plus the stored 24-hour alarm register.
// Optional macro ALARM_SET_PRELOAD_EN: entering edit preloads the fields from the stored alarm.
module alarm_setter #(
  parameter int NO_ALARM_HOUR = 24
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic       i_disp_mode,
  input  logic       i_set,
  input  logic       i_display,
  input  logic       i_clear,
  output logic [4:0] o_alarm_hours,
  output logic [5:0] o_alarm_minutes,
  output logic [1:0] o_edit_state,
  output logic       o_edit_is_pm,
  output logic [4:0] o_edit_hours,
  output logic [5:0] o_edit_minutes
);

  localparam logic [4:0] NO_ALARM = 5'(NO_ALARM_HOUR);

  // Field meaning depends on the latched format: 24h uses FIELD1=hour, FIELD2=min;
  // 12h uses FIELD1=AM/PM, FIELD2=hour, FIELD3=min.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIELD1 = 2'd1,
    ST_FIELD2 = 2'd2,
    ST_FIELD3 = 2'd3
  } state_t;

  state_t     r_state;
  logic       r_fmt;
  logic       r_is_pm;
  logic [4:0] r_hours;
  logic [5:0] r_minutes;
  logic [4:0] r_alarm_hours;
  logic [5:0] r_alarm_minutes;

  function automatic logic [4:0] inc24(input logic [4:0] h);
    return (h >= 5'd23) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [4:0] inc12(input logic [4:0] h);
    return (h >= 5'd12) ? 5'd1 : h + 5'd1;
  endfunction

  function automatic logic [5:0] inc60(input logic [5:0] m);
    return (m >= 6'd59) ? 6'd0 : m + 6'd1;
  endfunction

  function automatic logic [4:0] to24(input logic pm, input logic [4:0] h);
    if (!pm) return (h == 5'd12) ? 5'd0 : h;
    else     return (h == 5'd12) ? 5'd12 : h + 5'd12;
  endfunction

`ifdef ALARM_SET_PRELOAD_EN
  function automatic logic [4:0] to12(input logic [4:0] h);
    if (h == 5'd0)      return 5'd12;
    else if (h > 5'd12) return h - 5'd12;
    else                return h;
  endfunction
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state         <= ST_IDLE;
      r_fmt           <= 1'b0;
      r_is_pm         <= 1'b0;
      r_hours         <= 5'd0;
      r_minutes       <= 6'd0;
      r_alarm_hours   <= NO_ALARM;
      r_alarm_minutes <= 6'd0;
    end else if (i_enable) begin
      if (i_clear) begin
        r_state         <= ST_IDLE;
        r_alarm_hours   <= NO_ALARM;
        r_alarm_minutes <= 6'd0;
      end else if (i_set) begin
        case (r_state)
          ST_IDLE: begin
            r_fmt   <= i_disp_mode;
            r_state <= ST_FIELD1;
`ifdef ALARM_SET_PRELOAD_EN
            if (r_alarm_hours != NO_ALARM) begin
              r_minutes <= r_alarm_minutes;
              if (i_disp_mode) begin
                r_is_pm <= (r_alarm_hours >= 5'd12);
                r_hours <= to12(r_alarm_hours);
              end else begin
                r_is_pm <= 1'b0;
                r_hours <= r_alarm_hours;
              end
            end else begin
              r_is_pm   <= 1'b0;
              r_hours   <= i_disp_mode ? 5'd12 : 5'd0;
              r_minutes <= 6'd0;
            end
`else
            r_is_pm   <= 1'b0;
            r_hours   <= i_disp_mode ? 5'd12 : 5'd0;
            r_minutes <= 6'd0;
`endif
          end
          ST_FIELD1: r_state <= ST_FIELD2;
          ST_FIELD2: begin
            if (r_fmt) begin
              r_state <= ST_FIELD3;
            end else begin
              r_state         <= ST_IDLE;
              r_alarm_hours   <= r_hours;
              r_alarm_minutes <= r_minutes;
            end
          end
          ST_FIELD3: begin
            r_state         <= ST_IDLE;
            r_alarm_hours   <= to24(r_is_pm, r_hours);
            r_alarm_minutes <= r_minutes;
          end
          default: r_state <= ST_IDLE;
        endcase
      end else if (i_display) begin
        // IDLE display pulses belong to the external display-format toggle.
        case (r_state)
          ST_FIELD1: begin
            if (r_fmt) r_is_pm <= ~r_is_pm;
            else       r_hours <= inc24(r_hours);
          end
          ST_FIELD2: begin
            if (r_fmt) r_hours   <= inc12(r_hours);
            else       r_minutes <= inc60(r_minutes);
          end
          ST_FIELD3: r_minutes <= inc60(r_minutes);
          default: ;
        endcase
      end
    end
  end

  assign o_alarm_hours   = r_alarm_hours;
  assign o_alarm_minutes = r_alarm_minutes;
  assign o_edit_state    = r_state;
  assign o_edit_is_pm    = r_is_pm;
  assign o_edit_hours    = r_hours;
  assign o_edit_minutes  = r_minutes;

endmodule

// File: tb/tb_alarm_setter.sv
// Directed bench for alarm_setter: each step queues its expected outputs, drives the
// buttons, then pops the queue and compares against the DUT.
module tb_alarm_setter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       dispMode = 1'b0;
  logic       setBtn = 1'b0;
  logic       displayBtn = 1'b0;
  logic       clearBtn = 1'b0;
  logic [4:0] alarmHours;
  logic [5:0] alarmMinutes;
  logic [1:0] editState;
  logic       editIsPm;
  logic [4:0] editHours;
  logic [5:0] editMinutes;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [4:0] ah;
    logic [5:0] am;
    logic [1:0] st;
    logic       pm;
    logic [4:0] eh;
    logic [5:0] em;
  } exp_t;

  exp_t sb[$];

  alarm_setter #(.NO_ALARM_HOUR(24)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_enable       (enable),
    .i_disp_mode    (dispMode),
    .i_set          (setBtn),
    .i_display      (displayBtn),
    .i_clear        (clearBtn),
    .o_alarm_hours  (alarmHours),
    .o_alarm_minutes(alarmMinutes),
    .o_edit_state   (editState),
    .o_edit_is_pm   (editIsPm),
    .o_edit_hours   (editHours),
    .o_edit_minutes (editMinutes)
  );

  always #5 clk = ~clk;

  task automatic pushExpect(input string tag, input int ah, input int am, input int st,
                            input int pm, input int eh, input int em);
    exp_t e;
    e.tag = tag;
    e.ah = 5'(ah);
    e.am = 6'(am);
    e.st = 2'(st);
    e.pm = 1'(pm);
    e.eh = 5'(eh);
    e.em = 6'(em);
    sb.push_back(e);
  endtask

  task automatic cmpField(input string tag, input string field, input logic [7:0] obs,
                          input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, expv);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard empty observed=0 expected=1 entries");
    end else begin
      e = sb.pop_front();
      cmpField(e.tag, "alarm_hours", 8'(alarmHours), 8'(e.ah));
      cmpField(e.tag, "alarm_minutes", 8'(alarmMinutes), 8'(e.am));
      cmpField(e.tag, "edit_state", 8'(editState), 8'(e.st));
      cmpField(e.tag, "edit_is_pm", 8'(editIsPm), 8'(e.pm));
      cmpField(e.tag, "edit_hours", 8'(editHours), 8'(e.eh));
      cmpField(e.tag, "edit_minutes", 8'(editMinutes), 8'(e.em));
    end
  endtask

  // Drives one button combination for n cycles; called #1 after a rising edge.
  task automatic applyStimulus(input logic s, input logic d, input logic c, input logic en,
                               input logic mode, input int n);
    for (int i = 0; i < n; i++) begin
      setBtn = s;
      displayBtn = d;
      clearBtn = c;
      enable = en;
      dispMode = mode;
      @(posedge clk);
      #1;
      setBtn = 1'b0;
      displayBtn = 1'b0;
      clearBtn = 1'b0;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    pushExpect("reset", 24, 0, 0, 0, 0, 0);
    checkOutput();
    reset = 1'b0;
    enable = 1'b1;

    // 24-hour entry of 07:30
    pushExpect("h24_enter", 24, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 1); checkOutput();
    pushExpect("h24_hour7", 24, 0, 1, 0, 7, 0);
    applyStimulus(0, 1, 0, 1, 0, 7); checkOutput();
    pushExpect("h24_tomin", 24, 0, 2, 0, 7, 0);
    applyStimulus(1, 0, 0, 1, 0, 1); checkOutput();
    pushExpect("h24_min30", 24, 0, 2, 0, 7, 30);
    applyStimulus(0, 1, 0, 1, 0, 30); checkOutput();
    pushExpect("h24_commit", 7, 30, 0, 0, 7, 30);
    applyStimulus(1, 0, 0, 1, 0, 1); checkOutput();

    // Wrap checks on a fresh 24-hour edit
    pushExpect("h24_reenter", 7, 30, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 1); checkOutput();
    pushExpect("h24_hour23", 7, 30, 1, 0, 23, 0);
    applyStimulus(0, 1, 0, 1, 0, 23); checkOutput();
    pushExpect("h24_hourwrap", 7, 30, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0, 1); checkOutput();
    pushExpect("h24_tomin2", 7, 30, 2, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 1); checkOutput();
    pushExpect("h24_min59", 7, 30, 2, 0, 0, 59);
    applyStimulus(0, 1, 0, 1, 0, 59); checkOutput();
    pushExpect("h24_minwrap", 7, 30, 2, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0, 1); checkOutput();
    pushExpect("h24_min3", 7, 30, 2, 0, 0, 3);
    applyStimulus(0, 1, 0, 1, 0, 3); checkOutput();

    // Disabled buttons freeze the edit; clear then aborts it and disarms
    pushExpect("disabled_hold", 7, 30, 2, 0, 0, 3);
    applyStimulus(1, 1, 0, 0, 0, 2); checkOutput();
    pushExpect("clear_midedit", 24, 0, 0, 0, 0, 3);
    applyStimulus(0, 0, 1, 1, 0, 1); checkOutput();

    // Asynchronous reset during an edit
    pushExpect("pre_reset_edit", 24, 0, 1, 0, 2, 0);
    applyStimulus(1, 0, 0, 1, 0, 1);
    applyStimulus(0, 1, 0, 1, 0, 2); checkOutput();
    reset = 1'b1;
    #2;
    pushExpect("reset_midedit", 24, 0, 0, 0, 0, 0);
    checkOutput();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 12-hour entry of PM 1:05; disp_mode flipped mid-edit must be ignored
    pushExpect("h12_enter", 24, 0, 1, 0, 12, 0);
    applyStimulus(1, 0, 0, 1, 1, 1); checkOutput();
    pushExpect("h12_pm", 24, 0, 1, 1, 12, 0);
    applyStimulus(0, 1, 0, 1, 1, 1); checkOutput();
    pushExpect("h12_tohour", 24, 0, 2, 1, 12, 0);
    applyStimulus(1, 0, 0, 1, 0, 1); checkOutput();
    pushExpect("h12_hourwrap", 24, 0, 2, 1, 1, 0);
    applyStimulus(0, 1, 0, 1, 0, 1); checkOutput();
    pushExpect("h12_min5", 24, 0, 3, 1, 1, 5);
    applyStimulus(1, 0, 0, 1, 0, 1);
    applyStimulus(0, 1, 0, 1, 0, 5); checkOutput();
    pushExpect("h12_commit_1305", 13, 5, 0, 1, 1, 5);
    applyStimulus(1, 0, 0, 1, 0, 1); checkOutput();

    // AM 12:00 -> 00:00
    pushExpect("h12_am_enter", 13, 5, 1, 0, 12, 0);
    applyStimulus(1, 0, 0, 1, 1, 1); checkOutput();
    pushExpect("h12_am12_commit", 0, 0, 0, 0, 12, 0);
    applyStimulus(1, 0, 0, 1, 1, 3); checkOutput();

    // PM 12:00 -> 12:00
    pushExpect("h12_pm12_commit", 12, 0, 0, 1, 12, 0);
    applyStimulus(1, 0, 0, 1, 1, 1);
    applyStimulus(0, 1, 0, 1, 1, 1);
    applyStimulus(1, 0, 0, 1, 1, 3); checkOutput();

    // PM 11:00 -> 23:00
    pushExpect("h12_hour11", 12, 0, 2, 1, 11, 0);
    applyStimulus(1, 0, 0, 1, 1, 1);
    applyStimulus(0, 1, 0, 1, 1, 1);
    applyStimulus(1, 0, 0, 1, 1, 1);
    applyStimulus(0, 1, 0, 1, 1, 11); checkOutput();
    pushExpect("h12_pm11_commit", 23, 0, 0, 1, 11, 0);
    applyStimulus(1, 0, 0, 1, 1, 2); checkOutput();

    // Idle display has no effect; set and clear together lets clear win
    pushExpect("idle_display", 23, 0, 0, 1, 11, 0);
    applyStimulus(0, 1, 0, 1, 1, 1); checkOutput();
    pushExpect("set_clear_same", 24, 0, 0, 1, 11, 0);
    applyStimulus(1, 0, 1, 1, 1, 1); checkOutput();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
